// File: rtl/captura_texto_pkg.sv
// captura_texto_pkg
//   Shared definitions for the text-capture stage: FSM state encodings,
//   default buffer geometry and the backspace code. The translate stage uses
//   the same backspace value in its code table.
package captura_texto_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    ESPERA  = 2'd0,   // idle, waiting for the start key
    CAPTURA = 2'd1,   // storing characters
    LISTO   = 2'd2    // text complete, held for the display stage
  } estado_t;

  localparam int          DEPTH_DEF   = 32;
  localparam int          AW_DEF      = 5;
  localparam logic [6:0]  BS_CODE_DEF = 7'h08;

endpackage

// File: rtl/captura_texto_if.sv
// captura_texto_if
//   Bundles the key-event inputs, the display read port and the status outputs
//   of captura_texto.
//   master : upstream translate stage + display stage (drives keys, rd_addr)
//   slave  : captura_texto (drives rd_data and status)
//   Signals: valido, iniciar, terminar, traduccion[6:0], rd_addr[AW-1:0],
//            rd_data[6:0], longitud[AW:0], capturando, listo, lleno, desborde
interface captura_texto_if #(
  parameter int AW = 5
);
  logic          valido;
  logic          iniciar;
  logic          terminar;
  logic [6:0]    traduccion;
  logic [AW-1:0] rd_addr;
  logic [6:0]    rd_data;
  logic [AW:0]   longitud;
  logic          capturando;
  logic          listo;
  logic          lleno;
  logic          desborde;

  modport master (
    output valido, iniciar, terminar, traduccion, rd_addr,
    input  rd_data, longitud, capturando, listo, lleno, desborde
  );

  modport slave (
    input  valido, iniciar, terminar, traduccion, rd_addr,
    output rd_data, longitud, capturando, listo, lleno, desborde
  );
endinterface

// File: rtl/captura_texto_buffer_texto.sv
// buffer_texto
//   DEPTH x 7 simple dual-port character RAM: synchronous write, registered
//   read. A read and write to the same address in one cycle returns the old
//   data. Array contents are not reset; only the read register is.
//   Ports: clk, reset (async, active-high), we, waddr, wdata, raddr, rdata
module buffer_texto #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [6:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [6:0]    rdata
);

  logic [6:0] mem_r [DEPTH];
  logic [6:0] rdata_r;

  // Character storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; sees pre-write contents on a same-address collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= 7'd0;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/captura_texto.sv
// captura_texto
//   Captures translated key codes into a character buffer between a start key
//   (iniciar) and a stop key (terminar). The valido/iniciar/terminar levels are
//   turned into single-cycle events by rising-edge detectors. Backspace removes
//   the last character; writes beyond DEPTH set a sticky overflow flag.
//   Ports: clk, reset (async, active-high), bus (captura_texto_if.slave)
module captura_texto
  import captura_texto_pkg::*;
#(
  parameter int         DEPTH   = DEPTH_DEF,
  parameter int         AW      = AW_DEF,
  parameter logic [6:0] BS_CODE = BS_CODE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  captura_texto_if.slave bus
);

  localparam logic [AW:0] LONG_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LONG_UNO = (AW+1)'(1);

  estado_t       estado_r;
  estado_t       estado_next_s;
  logic [AW:0]   longitud_r;
  logic [AW:0]   longitud_next_s;
  logic          desborde_r;
  logic          desborde_next_s;
  logic          valido_q_r;
  logic          iniciar_q_r;
  logic          terminar_q_r;
  logic          v_p_s;
  logic          i_p_s;
  logic          t_p_s;
  logic          v_ok_s;
  logic          lleno_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [6:0]    rd_data_s;

  // Edge-detector history flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valido_q_r   <= 1'b0;
      iniciar_q_r  <= 1'b0;
      terminar_q_r <= 1'b0;
    end else begin
      valido_q_r   <= bus.valido;
      iniciar_q_r  <= bus.iniciar;
      terminar_q_r <= bus.terminar;
    end
  end

  assign v_p_s   = bus.valido   & ~valido_q_r;
  assign i_p_s   = bus.iniciar  & ~iniciar_q_r;
  assign t_p_s   = bus.terminar & ~terminar_q_r;
  // A character edge coinciding with a start/stop key belongs to that key
  assign v_ok_s  = v_p_s & ~bus.iniciar & ~bus.terminar;
  assign lleno_s = (longitud_r == LONG_MAX);
  assign waddr_s = longitud_r[AW-1:0];

  // State, length and overflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r   <= ESPERA;
      longitud_r <= '0;
      desborde_r <= 1'b0;
    end else begin
      estado_r   <= estado_next_s;
      longitud_r <= longitud_next_s;
      desborde_r <= desborde_next_s;
    end
  end

  // Next-state, length update and buffer write enable
  always_comb begin
    estado_next_s   = estado_r;
    longitud_next_s = longitud_r;
    desborde_next_s = desborde_r;
    we_s            = 1'b0;
    case (estado_r)
      ESPERA: begin
        if (i_p_s) begin
          estado_next_s   = CAPTURA;
          longitud_next_s = '0;
          desborde_next_s = 1'b0;
        end else begin
          estado_next_s = ESPERA;
        end
      end
      CAPTURA: begin
        if (t_p_s) begin
          estado_next_s = LISTO;
        end else if (i_p_s) begin
          longitud_next_s = '0;
          desborde_next_s = 1'b0;
        end else if (v_ok_s) begin
          if (bus.traduccion == BS_CODE) begin
            if (longitud_r != '0) begin
              longitud_next_s = longitud_r - LONG_UNO;
            end else begin
              longitud_next_s = longitud_r;
            end
          end else if (!lleno_s) begin
            we_s            = 1'b1;
            longitud_next_s = longitud_r + LONG_UNO;
          end else begin
            desborde_next_s = 1'b1;
          end
        end else begin
          estado_next_s = CAPTURA;
        end
      end
      LISTO: begin
        if (i_p_s) begin
          estado_next_s   = CAPTURA;
          longitud_next_s = '0;
          desborde_next_s = 1'b0;
        end else begin
          estado_next_s = LISTO;
        end
      end
      default: begin
        estado_next_s   = ESPERA;
        longitud_next_s = '0;
        desborde_next_s = 1'b0;
      end
    endcase
  end

  buffer_texto #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (bus.traduccion),
    .raddr (bus.rd_addr),
    .rdata (rd_data_s)
  );

  assign bus.rd_data    = rd_data_s;
  assign bus.longitud   = longitud_r;
  assign bus.capturando = (estado_r == CAPTURA);
  assign bus.listo      = (estado_r == LISTO);
  assign bus.lleno      = lleno_s;
  assign bus.desborde   = desborde_r;

endmodule

// File: tb/tb_captura_texto.sv
module tb_captura_texto;

  localparam int         DEPTH = 32;
  localparam int         AW    = 5;
  localparam logic [6:0] BS    = 7'h08;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  captura_texto_if #(.AW(AW)) intf ();

  captura_texto #(.DEPTH(DEPTH), .AW(AW), .BS_CODE(BS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 capturing, 2 done
  int         m_mode;
  logic [6:0] m_text [$];
  bit         m_ovf;
  logic [6:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  logic [6:0] m_rd;
  bit         m_rd_known;
  bit         pv, pi, pt;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_text.delete(); m_ovf = 1'b0;
      pv = 1'b0; pi = 1'b0; pt = 1'b0;
      m_rd = 7'd0; m_rd_known = 1'b1;
    end else begin
      bit vp, ip, tp;
      vp = intf.valido && !pv;
      ip = intf.iniciar && !pi;
      tp = intf.terminar && !pt;
      m_rd_known = m_known[intf.rd_addr];
      m_rd = m_mem[intf.rd_addr];
      if (m_mode == 1 && tp) begin
        m_mode = 2;
      end else if (ip) begin
        m_mode = 1; m_text.delete(); m_ovf = 1'b0;
      end else if (m_mode == 1 && vp && !intf.iniciar && !intf.terminar) begin
        if (intf.traduccion == BS) begin
          if (m_text.size() > 0) void'(m_text.pop_back());
        end else if (m_text.size() < DEPTH) begin
          m_mem[m_text.size()] = intf.traduccion;
          m_known[m_text.size()] = 1'b1;
          m_text.push_back(intf.traduccion);
        end else begin
          m_ovf = 1'b1;
        end
      end
      pv = intf.valido; pi = intf.iniciar; pt = intf.terminar;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("m_longitud",   int'(intf.longitud),   m_text.size());
      check("m_capturando", int'(intf.capturando), int'(m_mode == 1));
      check("m_listo",      int'(intf.listo),      int'(m_mode == 2));
      check("m_lleno",      int'(intf.lleno),      int'(m_text.size() == DEPTH));
      check("m_desborde",   int'(intf.desborde),   int'(m_ovf));
      if (m_rd_known) check("m_rd_data", int'(intf.rd_data), int'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ini();
    intf.iniciar = 1'b1; tick(1); intf.iniciar = 1'b0; tick(1);
  endtask

  task automatic pulse_ter();
    intf.terminar = 1'b1; tick(1); intf.terminar = 1'b0; tick(1);
  endtask

  task automatic send(input logic [6:0] c, input int hold);
    intf.traduccion = c; intf.valido = 1'b1; tick(hold);
    intf.valido = 1'b0; tick(1);
  endtask

  task automatic read_at(input int a, input int exp, input string name);
    intf.rd_addr = AW'(a); tick(1);
    check(name, int'(intf.rd_data), exp);
  endtask

  initial begin
    intf.valido = 1'b0; intf.iniciar = 1'b0; intf.terminar = 1'b0;
    intf.traduccion = 7'd0; intf.rd_addr = '0;
    #3 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(1);
    check("rst_longitud", int'(intf.longitud), 0);
    check("rst_rd_data", int'(intf.rd_data), 0);
    check("rst_capturando", int'(intf.capturando), 0);

    // 1: reset mid-capture with 3 chars
    pulse_ini();
    send(7'h61, 1); send(7'h62, 1); send(7'h63, 1);
    check("t1_longitud3", int'(intf.longitud), 3);
    reset = 1'b1; tick(1);
    check("t1_longitud", int'(intf.longitud), 0);
    check("t1_capturando", int'(intf.capturando), 0);
    check("t1_listo", int'(intf.listo), 0);
    check("t1_desborde", int'(intf.desborde), 0);
    reset = 1'b0; tick(1);

    // 2: H, O held 5 cycles each, then stop
    pulse_ini();
    send(7'h48, 5); send(7'h4F, 5);
    pulse_ter();
    check("t2_longitud", int'(intf.longitud), 2);
    check("t2_listo", int'(intf.listo), 1);
    read_at(0, 7'h48, "t2_rd0");
    read_at(1, 7'h4F, "t2_rd1");

    // 3: backspace three times from 2 chars
    pulse_ini();
    send(7'h41, 1); send(7'h42, 1);
    send(BS, 1); check("t3_bs1", int'(intf.longitud), 1);
    send(BS, 1); check("t3_bs2", int'(intf.longitud), 0);
    send(BS, 1); check("t3_bs3", int'(intf.longitud), 0);
    read_at(0, 7'h41, "t3_rd0_kept");

    // 4: DEPTH+1 chars
    pulse_ini();
    for (int i = 0; i < DEPTH; i++) send(7'(7'h41 + (i % 26)), 1);
    check("t4_lleno", int'(intf.lleno), 1);
    check("t4_desborde0", int'(intf.desborde), 0);
    send(7'h7A, 1);
    check("t4_longitud", int'(intf.longitud), DEPTH);
    check("t4_desborde1", int'(intf.desborde), 1);
    tick(4);
    check("t4_desborde_held", int'(intf.desborde), 1);
    read_at(DEPTH - 1, 7'h46, "t4_rd_last");
    read_at(0, 7'h41, "t4_rd_first");
    pulse_ini();
    check("t4_desborde_clr", int'(intf.desborde), 0);
    check("t4_lleno_clr", int'(intf.lleno), 0);

    // 5: valido and terminar rise together; valido in LISTO/ESPERA
    send(7'h31, 1); send(7'h32, 1);
    intf.traduccion = 7'h5A; intf.valido = 1'b1; intf.terminar = 1'b1; tick(1);
    intf.valido = 1'b0; intf.terminar = 1'b0; tick(1);
    check("t5_listo", int'(intf.listo), 1);
    check("t5_longitud", int'(intf.longitud), 2);
    send(7'h33, 1);
    check("t5_listo_nowrite", int'(intf.longitud), 2);
    read_at(2, 7'h43, "t5_rd2_untouched");
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    send(7'h34, 1);
    check("t5_espera_nowrite", int'(intf.longitud), 0);

    // 6: restart from LISTO after 4 chars
    pulse_ini();
    send(7'h50, 1); send(7'h51, 1); send(7'h52, 1); send(7'h53, 1);
    pulse_ter();
    check("t6_listo_len", int'(intf.longitud), 4);
    pulse_ini();
    check("t6_capturando", int'(intf.capturando), 1);
    check("t6_longitud0", int'(intf.longitud), 0);
    send(7'h6B, 1);
    read_at(0, 7'h6B, "t6_rd0_new");
    read_at(1, 7'h51, "t6_rd1_stale");
    check("t6_longitud1", int'(intf.longitud), 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
